// File: rtl/soc_system_sysid_pkg.sv
// Shared definitions for the system-ID checker and its bench.
//  - sysid_state_t : checker FSM states
//  - SYSID_ADDR_*  : word addresses of the system-ID slave
//  - SYSID_EXPECTED_ID / SYSID_EXPECTED_TS : default expected slave contents
package soc_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_DAT_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_DAT_TS = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAIL   = 3'd6
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID = 32'd2899645186;
    localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1448965834;

    // A run is in progress while a word is being requested or awaited.
    function automatic logic sysid_in_txn(input sysid_state_t s);
        return (s == ST_REQ_ID) || (s == ST_DAT_ID) ||
               (s == ST_REQ_TS) || (s == ST_DAT_TS);
    endfunction

endpackage

// File: rtl/soc_system_sysid_timeout.sv
// Per-word transaction timer: a loadable down-counter.
//  clock     in   rising-edge clock
//  reset_n   in   asynchronous active-low reset (counter -> 0)
//  i_load    in   restart the window: counter <= CYCLES-1
//  i_en      in   count down one step (saturates at 0)
//  o_expired out  counter has reached 0, i.e. the CYCLES-th cycle of the window
module soc_system_sysid_timeout #(
    parameter int CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp), compares both words with the expected values
// and reports the verdict. Runs once after reset and again on each start.
//  clock, reset_n          clock / async active-low reset
//  start                   1-cycle re-run request (only honoured when not busy)
//  avm_address/avm_read    read request, held until !avm_waitrequest
//  avm_waitrequest         interconnect stall
//  avm_readdata/valid      read response
//  id_value/ts_value       captured words
//  id_match/ts_match       compare results, valid with check_done
//  check_done              last run read both words
//  timeout_err             last run gave up after retries
//  busy                    run in progress
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_match,
    output logic        ts_match,
    output logic        check_done,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    sysid_state_t r_state;
    logic [3:0]   r_retry_cnt;

    logic w_is_req;
    logic w_in_txn;
    logic w_accept;
    logic w_capture;
    logic w_expired;
    logic w_timeout;
    logic w_can_retry;
    logic w_start_ok;
    logic w_tmr_load;

    assign w_is_req    = (r_state == ST_REQ_ID) || (r_state == ST_REQ_TS);
    assign w_in_txn    = sysid_in_txn(r_state);
    assign w_accept    = w_is_req && !avm_waitrequest;
    // A response is taken in the data phase, or in the request phase only
    // together with acceptance (zero-latency slave). A response seen while
    // the request is still stalled belongs to an abandoned request.
    assign w_capture   = avm_readdatavalid && (w_accept ||
                         (r_state == ST_DAT_ID) || (r_state == ST_DAT_TS));
    assign w_timeout   = w_in_txn && w_expired && !w_capture;
    assign w_can_retry = (r_retry_cnt < RETRY_LIMIT);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_FAIL));
    // Reload the window whenever a request phase is (re)entered.
    assign w_tmr_load  = (r_state == ST_IDLE) || w_start_ok || w_capture ||
                         (w_timeout && w_can_retry);

    soc_system_sysid_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_tmr_load),
        .i_en      (w_in_txn),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_retry_cnt <= '0;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            id_value    <= '0;
            ts_value    <= '0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            check_done  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                // Only reachable through reset: auto-start the first run.
                ST_IDLE: begin
                    r_state     <= ST_REQ_ID;
                    r_retry_cnt <= '0;
                    avm_read    <= 1'b1;
                    avm_address <= SYSID_ADDR_ID;
                    busy        <= 1'b1;
                end

                ST_REQ_ID, ST_DAT_ID: begin
                    if (w_capture) begin
                        id_value    <= avm_readdata;
                        r_retry_cnt <= '0;
                        r_state     <= ST_REQ_TS;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_TS;
                    end else if (w_timeout) begin
                        if (w_can_retry) begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                            r_state     <= ST_REQ_ID;
                            avm_read    <= 1'b1;
                            avm_address <= SYSID_ADDR_ID;
                        end else begin
                            r_state     <= ST_FAIL;
                            avm_read    <= 1'b0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_state  <= ST_DAT_ID;
                        avm_read <= 1'b0;
                    end
                end

                ST_REQ_TS, ST_DAT_TS: begin
                    if (w_capture) begin
                        ts_value    <= avm_readdata;
                        r_retry_cnt <= '0;
                        r_state     <= ST_DONE;
                        avm_read    <= 1'b0;
                        busy        <= 1'b0;
                        check_done  <= 1'b1;
                        // id_value is already registered; the timestamp is
                        // compared straight off the bus as it is captured.
                        id_match    <= (id_value == EXPECTED_ID);
                        ts_match    <= (avm_readdata == EXPECTED_TS);
                    end else if (w_timeout) begin
                        if (w_can_retry) begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                            r_state     <= ST_REQ_TS;
                            avm_read    <= 1'b1;
                            avm_address <= SYSID_ADDR_TS;
                        end else begin
                            r_state     <= ST_FAIL;
                            avm_read    <= 1'b0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_state  <= ST_DAT_TS;
                        avm_read <= 1'b0;
                    end
                end

                ST_DONE, ST_FAIL: begin
                    if (start) begin
                        r_state     <= ST_REQ_ID;
                        r_retry_cnt <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b1;
                        check_done  <= 1'b0;
                        timeout_err <= 1'b0;
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Self-checking bench for soc_system_sysid_checker. A behavioural Avalon
// slave with programmable waitrequest and read latency feeds the main
// instance; a second instance with a short timeout sees a slave that never
// answers.
module tb_soc_system_sysid_checker;
    import soc_system_sysid_pkg::*;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        avm_waitrequest   = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata      = 32'h0;

    logic        avm_address, avm_read;
    logic [31:0] id_value, ts_value;
    logic        id_match, ts_match, check_done, timeout_err, busy;

    logic        to_avm_address, to_avm_read;
    logic [31:0] to_id_value, to_ts_value;
    logic        to_id_match, to_ts_match, to_check_done, to_timeout_err, to_busy;

    always #5 clock = ~clock;

    soc_system_sysid_checker u_dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .id_match          (id_match),
        .ts_match          (ts_match),
        .check_done        (check_done),
        .timeout_err       (timeout_err),
        .busy              (busy)
    );

    soc_system_sysid_checker #(
        .TIMEOUT_CYCLES (16),
        .MAX_RETRIES    (2)
    ) u_dut_to (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (to_avm_address),
        .avm_read          (to_avm_read),
        .avm_waitrequest   (1'b0),
        .avm_readdata      (32'h0),
        .avm_readdatavalid (1'b0),
        .id_value          (to_id_value),
        .ts_value          (to_ts_value),
        .id_match          (to_id_match),
        .ts_match          (to_ts_match),
        .check_done        (to_check_done),
        .timeout_err       (to_timeout_err),
        .busy              (to_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural slave (drives on the falling edge) -------
    logic [31:0] cfg_id   = SYSID_EXPECTED_ID;
    logic [31:0] cfg_ts   = SYSID_EXPECTED_TS;
    int          cfg_wait = 0;
    int          cfg_lat  = 1;
    int          wait_left = 0;
    bit          pend_valid = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_data  = 32'h0;
    int          acc_id = 0, acc_ts = 0, first_addr = -1;
    int          stall_cnt = 0, stab_err = 0;
    bit          stall_prev = 1'b0;
    logic        addr_prev  = 1'b0;

    always @(negedge clock) begin
        // A stalled request must reappear unchanged in the next cycle.
        if (reset_n && stall_prev && (!avm_read || avm_address !== addr_prev))
            stab_err++;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'h0;
        avm_waitrequest   = 1'b0;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
                pend_valid        = 1'b0;
            end
        end
        if (avm_read) begin
            if (wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left--;
                stall_cnt++;
            end else begin
                if (first_addr < 0) first_addr = int'(avm_address);
                if (avm_address) acc_ts++; else acc_id++;
                wait_left = cfg_wait;
                if (cfg_lat == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = avm_address ? cfg_ts : cfg_id;
                end else begin
                    pend_valid = 1'b1;
                    pend_cnt   = cfg_lat;
                    pend_data  = avm_address ? cfg_ts : cfg_id;
                end
            end
        end
        stall_prev = reset_n && avm_read && avm_waitrequest;
        addr_prev  = avm_address;
    end

    // ---------------- monitor for the short-timeout instance ---------------
    int to_edges = 0, to_fail_edge = -1, to_req_id = 0, to_req_ts = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            to_edges = 0; to_fail_edge = -1; to_req_id = 0; to_req_ts = 0;
        end else if (to_fail_edge < 0) begin
            to_edges++;
            #1;
            if (to_avm_read) begin
                if (to_avm_address) to_req_ts++; else to_req_id++;
            end
            if (to_timeout_err) to_fail_edge = to_edges;
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic clear_slave();
        acc_id = 0; acc_ts = 0; first_addr = -1; stall_cnt = 0;
        wait_left = cfg_wait;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (!(check_done || timeout_err) && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        ok = check_done || timeout_err;
    endtask

    task automatic wait_acc(input bit ts, output bit ok);
        int n = 0;
        while (((ts ? acc_ts : acc_id) < 1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        ok = (ts ? acc_ts : acc_id) >= 1;
    endtask

    typedef struct {
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          wait_cyc;
        int          lat;
        logic        exp_id_match;
        logic        exp_ts_match;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  ok;
        logic [70:0] all_out;

        vecs[0] = '{SYSID_EXPECTED_ID, SYSID_EXPECTED_TS, 0,  1, 1'b1, 1'b1};
        vecs[1] = '{32'h0000_0001,     SYSID_EXPECTED_TS, 0,  1, 1'b0, 1'b1};
        vecs[2] = '{SYSID_EXPECTED_ID, SYSID_EXPECTED_TS, 20, 0, 1'b1, 1'b1};
        vecs[3] = '{SYSID_EXPECTED_ID, 32'hDEAD_BEEF,     0,  0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000,     32'h0000_0000,     3,  2, 1'b0, 1'b0};

        // ---- reset values, then auto-run with a well-behaved slave --------
        clear_slave();
        repeat (3) @(negedge clock);
        all_out = {avm_read, avm_address, busy, check_done, timeout_err,
                   id_match, ts_match, id_value, ts_value};
        check("reset_outputs", 96'(all_out), 96'h0);
        reset_n = 1'b1;
        wait_done(20, cyc, ok);
        check("auto_run_done", 96'(ok), 96'h1);
        check("auto_run_within_6", 96'(cyc <= 6), 96'h1);
        check("auto_id_match", 96'(id_match), 96'h1);
        check("auto_ts_match", 96'(ts_match), 96'h1);
        check("auto_busy_low", 96'(busy), 96'h0);
        check("auto_first_addr", 96'(first_addr), 96'h0);
        check("auto_reads_id", 96'(acc_id), 96'h1);
        check("auto_reads_ts", 96'(acc_ts), 96'h1);

        // ---- silent slave on the 16-cycle / 2-retry instance --------------
        cyc = 0;
        while (to_fail_edge < 0 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("to_timeout_err", 96'(to_timeout_err), 96'h1);
        check("to_check_done", 96'(to_check_done), 96'h0);
        check("to_busy", 96'(to_busy), 96'h0);
        check("to_requests_id", 96'(to_req_id), 96'h3);
        check("to_requests_ts", 96'(to_req_ts), 96'h0);
        check("to_fail_near_48", 96'(to_fail_edge >= 47 && to_fail_edge <= 51), 96'h1);

        // ---- table-driven runs ---------------------------------------------
        for (int i = 0; i < 5; i++) begin
            cfg_id = vecs[i].id_data;  cfg_ts  = vecs[i].ts_data;
            cfg_wait = vecs[i].wait_cyc; cfg_lat = vecs[i].lat;
            clear_slave();
            pulse_start();
            wait_done(200, cyc, ok);
            check($sformatf("v%0d_done", i), 96'(check_done), 96'h1);
            check($sformatf("v%0d_timeout", i), 96'(timeout_err), 96'h0);
            check($sformatf("v%0d_id_value", i), 96'(id_value), 96'(vecs[i].id_data));
            check($sformatf("v%0d_ts_value", i), 96'(ts_value), 96'(vecs[i].ts_data));
            check($sformatf("v%0d_id_match", i), 96'(id_match), 96'(vecs[i].exp_id_match));
            check($sformatf("v%0d_ts_match", i), 96'(ts_match), 96'(vecs[i].exp_ts_match));
            check($sformatf("v%0d_reads", i), 96'({acc_id, acc_ts}), {32'h0, 32'd1, 32'd1});
            check($sformatf("v%0d_stalls", i), 96'(stall_cnt), 96'(2 * vecs[i].wait_cyc));
        end

        // ---- start while busy (DAT_TS) is ignored; start in DONE reruns ----
        cfg_id = SYSID_EXPECTED_ID; cfg_ts = SYSID_EXPECTED_TS;
        cfg_wait = 0; cfg_lat = 4;
        clear_slave();
        pulse_start();
        wait_acc(1'b1, ok);
        check("busy_start_ts_accepted", 96'(ok), 96'h1);
        pulse_start();
        wait_done(50, cyc, ok);
        repeat (5) @(negedge clock);
        check("busy_start_done", 96'(check_done), 96'h1);
        check("busy_start_no_rerun", 96'({acc_id, acc_ts, 31'h0, busy}), {32'd1, 32'd1, 32'd0});
        pulse_start();
        check("done_start_clears", 96'({check_done, id_match, ts_match, busy}), 96'h1);
        wait_done(50, cyc, ok);
        check("done_start_rerun_pass", 96'({check_done, id_match, ts_match}), 96'h7);

        // ---- reset in DAT_ID with the response arriving after release ------
        cfg_id = 32'hBAD0_BAD0; cfg_wait = 0; cfg_lat = 8;
        clear_slave();
        pulse_start();
        wait_acc(1'b0, ok);
        check("rst_first_req_accepted", 96'(ok), 96'h1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        all_out = {avm_read, avm_address, busy, check_done, timeout_err,
                   id_match, ts_match, id_value, ts_value};
        check("rst_outputs_zero", 96'(all_out), 96'h0);
        cfg_id = SYSID_EXPECTED_ID; cfg_wait = 6; wait_left = 6;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(200, cyc, ok);
        check("rst_rerun_done", 96'(check_done), 96'h1);
        check("rst_id_value", 96'(id_value), 96'(SYSID_EXPECTED_ID));
        check("rst_matches", 96'({id_match, ts_match}), 96'h3);
        check("rst_reads", 96'({acc_id, acc_ts}), {32'h0, 32'd2, 32'd1});

        check("request_stable_under_stall", 96'(stab_err), 96'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
